mips_divider: RTL and testbench

Multi-cycle 32-bit integer divider for the MIPS execute stage, serving DIV and DIVU. It computes quotient and remainder by restoring division, one trial subtraction per clock. It is the inverse of the datapath adder: it subtracts repeatedly where the adder adds once. Results feed the HI/LO registers: quotient goes to LO and remainder to HI. The control unit stalls on `busy`.

---
 rtl/mips_pkg.sv | 18 +
 rtl/mips_divider_div_step.sv | 24 ++
 rtl/mips_divider.sv | 155 +++++++++++++++
 tb/tb_mips_divider.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execute-stage divider.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  // Step-counter width for a given operand width (at least one bit).
  function automatic int div_count_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_COUNT_W = $clog2(DIV_WIDTH);

endpackage

// File: rtl/mips_divider_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // Compare over WIDTH+1 bits; when the subtraction succeeds the difference
  // is below the divisor, so the low WIDTH bits of the modular result suffice.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted[WIDTH-1:0] - divisor;
    q_bit   = (shifted >= {1'b0, divisor});
    rem_out = q_bit ? diff : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mips_divider.sv
// Multi-cycle restoring divider for DIV/DIVU; quotient -> LO, remainder -> HI.
// Define MIPS_DIVIDER_SIGNED_EN to build signed (DIV) support; without it
// every operation is DIVU and is_signed is ignored.
module mips_divider
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int             CW   = div_count_w(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_rem;
  logic             step_bit;

`ifdef MIPS_DIVIDER_SIGNED_EN
  logic q_neg_q, q_neg_d;
  logic r_neg_q, r_neg_d;
  logic a_neg, b_neg;

  assign a_neg = is_signed & dividend[WIDTH-1];
  assign b_neg = is_signed & divisor[WIDTH-1];
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in (prem_q),
    .bit_in (quo_q[WIDTH-1]),
    .divisor(dvsr_q),
    .rem_out(step_rem),
    .q_bit  (step_bit)
  );

  // Next-state and datapath: accept in IDLE, one step per RUN cycle, sign fix in FIX.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    prem_d        = prem_q;
    quo_d         = quo_q;
    dvsr_d        = dvsr_q;
    dz_d          = dz_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    done_d        = 1'b0;
`ifdef MIPS_DIVIDER_SIGNED_EN
    q_neg_d       = q_neg_q;
    r_neg_d       = r_neg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          count_d = '0;
          prem_d  = '0;
          dz_d    = (divisor == '0);
`ifdef MIPS_DIVIDER_SIGNED_EN
          quo_d   = a_neg ? -dividend : dividend;
          dvsr_d  = b_neg ? -divisor : divisor;
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
`else
          quo_d   = dividend;
          dvsr_d  = divisor;
`endif
        end
      end
      RUN: begin
        prem_d  = step_rem;
        quo_d   = {quo_q[WIDTH-2:0], step_bit};
        count_d = count_q + CW'(1);
        if (count_q == LAST) state_d = FIX;
      end
      FIX: begin
`ifdef MIPS_DIVIDER_SIGNED_EN
        quotient_d  = q_neg_q ? -quo_q : quo_q;
        remainder_d = r_neg_q ? -prem_q : prem_q;
`else
        quotient_d  = quo_q;
        remainder_d = prem_q;
`endif
        div_by_zero_d = dz_q;
        done_d        = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      count_q       <= '0;
      prem_q        <= '0;
      quo_q         <= '0;
      dvsr_q        <= '0;
      dz_q          <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      done_q        <= 1'b0;
`ifdef MIPS_DIVIDER_SIGNED_EN
      q_neg_q       <= 1'b0;
      r_neg_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      prem_q        <= prem_d;
      quo_q         <= quo_d;
      dvsr_q        <= dvsr_d;
      dz_q          <= dz_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      done_q        <= done_d;
`ifdef MIPS_DIVIDER_SIGNED_EN
      q_neg_q       <= q_neg_d;
      r_neg_q       <= r_neg_d;
`endif
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_mips_divider.sv
// Scoreboard bench for mips_divider: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_mips_divider;

`ifdef MIPS_DIVIDER_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  mips_divider #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual=done required=no_done q=%h r=%h", quotient, remainder);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the accept edge E0.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Issue one op, optionally pulse a stray start mid-flight, and check timing.
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s,
                     input logic [31:0] eq, input logic [31:0] er, input logic edz,
                     input bit inject);
    int cyc;
    int busy_bad;
    exp_t e;
    e.q = eq; e.r = er; e.dz = edz;
    sb.push_back(e);
    start_op(a, b, s);
    cyc = 0;
    busy_bad = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy !== 1'b1) busy_bad++;
      if (inject && cyc == 10) begin
        dividend = 32'd1; divisor = 32'd1; is_signed = 1'b0; start = 1'b1;
      end
      if (inject && cyc == 11) start = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    check("latency", cyc, 33);
    check("busy_during_op", busy_bad, 0);
    check("busy_in_done_cycle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    run(32'hFFFF_FFF9, 32'd2, 1'b1,
        SGN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC, SGN ? 32'hFFFF_FFFF : 32'd1, 1'b0, 1'b0);
    run(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0);
    run(32'd7, 32'hFFFF_FFFE, 1'b1,
        SGN ? 32'hFFFF_FFFD : 32'd0, SGN ? 32'd1 : 32'd7, 1'b0, 1'b0);
    run(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
    run(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0);
    run(32'hFFFF_FFFB, 32'd0, 1'b1,
        SGN ? 32'd1 : 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
        SGN ? 32'h8000_0000 : 32'd0, SGN ? 32'd0 : 32'h8000_0000, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    run(32'd1000, 32'd13, 1'b0, 32'd76, 32'd12, 1'b0, 1'b1);
    run(32'hDEAD_BEEF, 32'h0001_0000, 1'b0, 32'h0000_DEAD, 32'h0000_BEEF, 1'b0, 1'b0);

    // Reset during step 10 discards the result and clears the outputs.
    start_op(32'd1000, 32'd3, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_quotient", quotient, 32'd0);
    check("midrst_remainder", remainder, 32'd0);
    check("midrst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("idle_after_rst_busy", {31'd0, busy}, 32'd0);
    run(32'd20, 32'd6, 1'b0, 32'd3, 32'd2, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("results_hold_q", quotient, 32'd3);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
